// File: rtl/guess_judge.sv
// guess_judge: keypad digit collection, secret registration for two players,
// turn alternation and strike/ball scoring of each guess against the
// opponent's secret. Scored guesses are emitted as one-cycle write pulses.
module guess_judge #(
   parameter int unsigned MAX_ROUNDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        game_start,
   output logic        on_game,
   output logic [11:0] input_number,
   output logic        button_pressed_p1,
   output logic        button_pressed_p2,
   output logic [1:0]  strike1,
   output logic [1:0]  ball1,
   output logic [1:0]  strike2,
   output logic [1:0]  ball2,
   output logic        cur_player,
   output logic        entry_err,
   output logic [1:0]  winner
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_P1,
      S_SET_P2,
      S_PLAY,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [11:0] r_buf;
   logic [1:0]  r_cnt;
   logic [11:0] r_secret1;
   logic [11:0] r_secret2;
   logic [3:0]  r_round1;
   logic [3:0]  r_round2;

   logic        w_key_digit;
   logic        w_key_clear;
   logic        w_key_enter;
   logic        w_buf_ok;
   logic        w_start;
   logic        w_game_end;
   logic        w_keys_on;
   logic        w_accept;
   logic [3:0]  w_score_p1;
   logic [3:0]  w_score_p2;

   // Returns {strike, ball} of guess g against secret s (digit 2 in [11:8]).
   function automatic logic [3:0] score(input logic [11:0] g, input logic [11:0] s);
      logic [1:0] st;
      logic [1:0] bl;
      st = '0;
      bl = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         for (int unsigned j = 0; j < 3; j++) begin
            if (g[i*4 +: 4] == s[j*4 +: 4]) begin
               if (i == j) st = st + 2'd1;
               else        bl = bl + 2'd1;
            end
         end
      end
      return {st, bl};
   endfunction

   assign w_key_digit = key_valid && (key_code <= 4'd9);
   assign w_key_clear = key_valid && (key_code == 4'hA);
   assign w_key_enter = key_valid && (key_code == 4'hB);
   assign w_buf_ok    = (r_cnt == 2'd3) && (r_buf[11:8] != r_buf[7:4]) &&
                        (r_buf[7:4] != r_buf[3:0]) && (r_buf[11:8] != r_buf[3:0]);
   assign w_start     = game_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // The game ends while the final score pulse is still on the outputs.
   assign w_game_end  = (r_state == S_PLAY) &&
                        ((button_pressed_p1 && (strike1 == 2'd3)) ||
                         (button_pressed_p2 && ((strike2 == 2'd3) ||
                                                (r_round2 == 4'(MAX_ROUNDS)))));
   assign w_keys_on   = ((r_state == S_SET_P1) || (r_state == S_SET_P2) ||
                         (r_state == S_PLAY)) && !w_game_end;
   assign w_accept    = w_keys_on && w_key_enter && w_buf_ok;
   assign w_score_p1  = score(r_buf, r_secret2);
   assign w_score_p2  = score(r_buf, r_secret1);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start)    w_state_nxt = S_SET_P1;
         S_SET_P1: if (w_accept)   w_state_nxt = S_SET_P2;
         S_SET_P2: if (w_accept)   w_state_nxt = S_PLAY;
         S_PLAY:   if (w_game_end) w_state_nxt = S_DONE;
         S_DONE:   if (w_start)    w_state_nxt = S_SET_P1;
         default:                  w_state_nxt = S_IDLE;
      endcase
   end

   // State-derived outputs; PLAY still covers the final pulse cycle.
   always_comb begin
      on_game = (r_state == S_PLAY);
   end

   // Digit buffer, secrets, scoring, turn and winner registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_buf             <= '0;
         r_cnt             <= '0;
         r_secret1         <= '0;
         r_secret2         <= '0;
         r_round1          <= '0;
         r_round2          <= '0;
         input_number      <= '0;
         button_pressed_p1 <= 1'b0;
         button_pressed_p2 <= 1'b0;
         strike1           <= '0;
         ball1             <= '0;
         strike2           <= '0;
         ball2             <= '0;
         cur_player        <= 1'b0;
         entry_err         <= 1'b0;
         winner            <= '0;
      end else begin
         button_pressed_p1 <= 1'b0;
         button_pressed_p2 <= 1'b0;
         entry_err         <= 1'b0;
         if (w_start) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_secret1    <= '0;
            r_secret2    <= '0;
            r_round1     <= '0;
            r_round2     <= '0;
            input_number <= '0;
            strike1      <= '0;
            ball1        <= '0;
            strike2      <= '0;
            ball2        <= '0;
            cur_player   <= 1'b0;
            winner       <= '0;
         end else if (w_game_end) begin
            r_buf <= '0;
            r_cnt <= '0;
            if (button_pressed_p1 && (strike1 == 2'd3))      winner <= 2'd1;
            else if (button_pressed_p2 && (strike2 == 2'd3)) winner <= 2'd2;
            else                                             winner <= 2'd3;
         end else if (w_keys_on) begin
            if (w_key_digit && (r_cnt != 2'd3)) begin
               r_buf <= {r_buf[7:0], key_code};
               r_cnt <= r_cnt + 2'd1;
            end else if (w_key_clear) begin
               r_buf <= '0;
               r_cnt <= '0;
            end else if (w_key_enter) begin
               r_buf <= '0;
               r_cnt <= '0;
               if (!w_buf_ok) begin
                  entry_err <= 1'b1;
               end else begin
                  case (r_state)
                     S_SET_P1: begin
                        r_secret1  <= r_buf;
                        cur_player <= 1'b1;
                     end
                     S_SET_P2: begin
                        r_secret2  <= r_buf;
                        cur_player <= 1'b0;
                     end
                     default: begin
                        input_number <= r_buf;
                        cur_player   <= ~cur_player;
                        if (!cur_player) begin
                           button_pressed_p1 <= 1'b1;
                           {strike1, ball1}  <= w_score_p1;
                           r_round1          <= r_round1 + 4'd1;
                        end else begin
                           button_pressed_p2 <= 1'b1;
                           {strike2, ball2}  <= w_score_p2;
                           r_round2          <= r_round2 + 4'd1;
                        end
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_guess_judge.sv
// Directed testbench for guess_judge: secrets, scoring, entry errors,
// mid-game reset, strike-out win and round-limit draw.
module tb_guess_judge;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        game_start;
   logic        on_game;
   logic [11:0] input_number;
   logic        button_pressed_p1;
   logic        button_pressed_p2;
   logic [1:0]  strike1;
   logic [1:0]  ball1;
   logic [1:0]  strike2;
   logic [1:0]  ball2;
   logic        cur_player;
   logic        entry_err;
   logic [1:0]  winner;

   int unsigned n_checks;
   int unsigned n_fail;

   guess_judge #(.MAX_ROUNDS(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .key_valid         (key_valid),
      .key_code          (key_code),
      .game_start        (game_start),
      .on_game           (on_game),
      .input_number      (input_number),
      .button_pressed_p1 (button_pressed_p1),
      .button_pressed_p2 (button_pressed_p2),
      .strike1           (strike1),
      .ball1             (ball1),
      .strike2           (strike2),
      .ball2             (ball2),
      .cur_player        (cur_player),
      .entry_err         (entry_err),
      .winner            (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keys are driven at the negedge and sampled at the next posedge;
   // the task returns on the following negedge, inside the result cycle.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic enter_guess(input logic [11:0] g);
      press(g[11:8]);
      press(g[7:4]);
      press(g[3:0]);
      press(4'hB);
   endtask

   task automatic start_game();
      @(negedge clk);
      game_start = 1'b1;
      @(negedge clk);
      game_start = 1'b0;
   endtask

   task automatic test_reset_state();
      n_checks++;
      if ({on_game, input_number, button_pressed_p1, button_pressed_p2, strike1, ball1,
           strike2, ball2, cur_player, entry_err, winner} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_state: outputs=%h expected 0", {on_game, input_number,
                  button_pressed_p1, button_pressed_p2, strike1, ball1, strike2, ball2,
                  cur_player, entry_err, winner});
      end
   endtask

   task automatic test_secrets();
      start_game();
      n_checks++;
      if ({on_game, cur_player} !== 2'b00) begin
         n_fail++;
         $display("FAIL set_p1_entry: on_game,cur=%b expected 00", {on_game, cur_player});
      end
      enter_guess(12'h123);
      n_checks++;
      if ({on_game, cur_player, button_pressed_p1, button_pressed_p2, entry_err} !== 5'b01000) begin
         n_fail++;
         $display("FAIL secret_p1: on,cur,p1,p2,err=%b expected 01000",
                  {on_game, cur_player, button_pressed_p1, button_pressed_p2, entry_err});
      end
      enter_guess(12'h456);
      n_checks++;
      if ({on_game, cur_player, button_pressed_p1, button_pressed_p2, entry_err} !== 5'b10000) begin
         n_fail++;
         $display("FAIL secret_p2: on,cur,p1,p2,err=%b expected 10000",
                  {on_game, cur_player, button_pressed_p1, button_pressed_p2, entry_err});
      end
   endtask

   task automatic test_score();
      enter_guess(12'h654);
      n_checks++;
      if ({button_pressed_p1, button_pressed_p2, input_number, strike1, ball1, cur_player, on_game}
          !== {2'b10, 12'h654, 2'd1, 2'd2, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL score_p1: p1=%b p2=%b num=%h s=%0d b=%0d cur=%b on=%b expected 1 0 654 1 2 1 1",
                  button_pressed_p1, button_pressed_p2, input_number, strike1, ball1, cur_player, on_game);
      end
      @(negedge clk);
      n_checks++;
      if ({button_pressed_p1, strike1, ball1, input_number} !== {1'b0, 2'd1, 2'd2, 12'h654}) begin
         n_fail++;
         $display("FAIL score_hold: p1=%b s=%0d b=%0d num=%h expected 0 1 2 654",
                  button_pressed_p1, strike1, ball1, input_number);
      end
   endtask

   task automatic test_errors();
      enter_guess(12'h112);
      n_checks++;
      if ({entry_err, button_pressed_p1, button_pressed_p2, cur_player} !== 4'b1001) begin
         n_fail++;
         $display("FAIL err_repeat: err,p1,p2,cur=%b expected 1001",
                  {entry_err, button_pressed_p1, button_pressed_p2, cur_player});
      end
      @(negedge clk);
      n_checks++;
      if (entry_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse_width: err=%b expected 0", entry_err);
      end
      press(4'd7);
      press(4'd8);
      press(4'hB);
      n_checks++;
      if ({entry_err, button_pressed_p1, button_pressed_p2, cur_player} !== 4'b1001) begin
         n_fail++;
         $display("FAIL err_short: err,p1,p2,cur=%b expected 1001",
                  {entry_err, button_pressed_p1, button_pressed_p2, cur_player});
      end
      // Fourth digit must be dropped; 789 vs P1 secret 123 scores 0/0.
      press(4'd7);
      press(4'd8);
      press(4'd9);
      press(4'd0);
      press(4'hB);
      n_checks++;
      if ({entry_err, button_pressed_p2, input_number, strike2, ball2, cur_player}
          !== {2'b01, 12'h789, 2'd0, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL fourth_digit: err=%b p2=%b num=%h s=%0d b=%0d cur=%b expected 0 1 789 0 0 0",
                  entry_err, button_pressed_p2, input_number, strike2, ball2, cur_player);
      end
      // Clear discards the buffered 9; 321 vs 456 scores 0/0.
      press(4'd9);
      press(4'hA);
      enter_guess(12'h321);
      n_checks++;
      if ({button_pressed_p1, input_number, strike1, ball1, cur_player}
          !== {1'b1, 12'h321, 2'd0, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL clear_key: p1=%b num=%h s=%0d b=%0d cur=%b expected 1 321 0 0 1",
                  button_pressed_p1, input_number, strike1, ball1, cur_player);
      end
   endtask

   task automatic test_reset_mid_play();
      press(4'd1);
      press(4'd2);
      @(negedge clk);
      rst        = 1'b0;
      key_valid  = 1'b1;
      key_code   = 4'd3;
      game_start = 1'b1;
      @(negedge clk);
      rst        = 1'b1;
      key_valid  = 1'b0;
      game_start = 1'b0;
      n_checks++;
      if ({on_game, input_number, button_pressed_p1, button_pressed_p2, strike1, ball1,
           strike2, ball2, cur_player, entry_err, winner} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_mid_play: outputs=%h expected 0", {on_game, input_number,
                  button_pressed_p1, button_pressed_p2, strike1, ball1, strike2, ball2,
                  cur_player, entry_err, winner});
      end
      enter_guess(12'h123);
      n_checks++;
      if ({on_game, input_number, button_pressed_p1, button_pressed_p2, entry_err, cur_player}
          !== 17'd0) begin
         n_fail++;
         $display("FAIL idle_keys: on=%b num=%h p1=%b p2=%b err=%b cur=%b expected all 0",
                  on_game, input_number, button_pressed_p1, button_pressed_p2, entry_err, cur_player);
      end
   endtask

   task automatic test_win();
      start_game();
      enter_guess(12'h123);
      enter_guess(12'h456);
      enter_guess(12'h789);
      n_checks++;
      if ({button_pressed_p1, strike1, ball1} !== {1'b1, 2'd0, 2'd0}) begin
         n_fail++;
         $display("FAIL win_p1_miss: p1=%b s=%0d b=%0d expected 1 0 0", button_pressed_p1, strike1, ball1);
      end
      enter_guess(12'h123);
      n_checks++;
      if ({button_pressed_p2, strike2, ball2, on_game, input_number, winner}
          !== {1'b1, 2'd3, 2'd0, 1'b1, 12'h123, 2'd0}) begin
         n_fail++;
         $display("FAIL win_pulse: p2=%b s=%0d b=%0d on=%b num=%h win=%0d expected 1 3 0 1 123 0",
                  button_pressed_p2, strike2, ball2, on_game, input_number, winner);
      end
      @(negedge clk);
      n_checks++;
      if ({winner, on_game, button_pressed_p2, strike2, input_number}
          !== {2'd2, 1'b0, 1'b0, 2'd3, 12'h123}) begin
         n_fail++;
         $display("FAIL win_done: win=%0d on=%b p2=%b s=%0d num=%h expected 2 0 0 3 123",
                  winner, on_game, button_pressed_p2, strike2, input_number);
      end
      enter_guess(12'h456);
      n_checks++;
      if ({winner, on_game, button_pressed_p1, button_pressed_p2, entry_err, input_number}
          !== {2'd2, 4'b0000, 12'h123}) begin
         n_fail++;
         $display("FAIL done_hold: win=%0d on=%b p1=%b p2=%b err=%b num=%h expected 2 0 0 0 0 123",
                  winner, on_game, button_pressed_p1, button_pressed_p2, entry_err, input_number);
      end
   endtask

   task automatic test_draw();
      logic [11:0] guesses [8];
      logic [1:0]  exp_s   [8];
      logic [1:0]  exp_b   [8];
      guesses = '{12'h654, 12'h132, 12'h457, 12'h789, 12'h560, 12'h321, 12'h465, 12'h124};
      exp_s   = '{2'd1,    2'd1,    2'd2,    2'd0,    2'd0,    2'd1,    2'd1,    2'd2};
      exp_b   = '{2'd2,    2'd2,    2'd0,    2'd0,    2'd2,    2'd2,    2'd2,    2'd0};
      start_game();
      n_checks++;
      if ({winner, strike2, ball2, input_number, on_game, cur_player} !== 20'd0) begin
         n_fail++;
         $display("FAIL restart_clear: win=%0d s2=%0d b2=%0d num=%h on=%b cur=%b expected all 0",
                  winner, strike2, ball2, input_number, on_game, cur_player);
      end
      enter_guess(12'h123);
      enter_guess(12'h456);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) start_game();
         enter_guess(guesses[i]);
         n_checks++;
         if (i % 2 == 0) begin
            if ({button_pressed_p1, button_pressed_p2, strike1, ball1, input_number, on_game, winner}
                !== {2'b10, exp_s[i], exp_b[i], guesses[i], 1'b1, 2'd0}) begin
               n_fail++;
               $display("FAIL draw_guess_%0d: p1=%b p2=%b s=%0d b=%0d num=%h on=%b win=%0d expected 1 0 %0d %0d %h 1 0",
                        i, button_pressed_p1, button_pressed_p2, strike1, ball1, input_number,
                        on_game, winner, exp_s[i], exp_b[i], guesses[i]);
            end
         end else begin
            if ({button_pressed_p1, button_pressed_p2, strike2, ball2, input_number, on_game, winner}
                !== {2'b01, exp_s[i], exp_b[i], guesses[i], 1'b1, 2'd0}) begin
               n_fail++;
               $display("FAIL draw_guess_%0d: p1=%b p2=%b s=%0d b=%0d num=%h on=%b win=%0d expected 0 1 %0d %0d %h 1 0",
                        i, button_pressed_p1, button_pressed_p2, strike2, ball2, input_number,
                        on_game, winner, exp_s[i], exp_b[i], guesses[i]);
            end
         end
      end
      @(negedge clk);
      n_checks++;
      if ({winner, on_game} !== {2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL draw_done: win=%0d on=%b expected 3 0", winner, on_game);
      end
      start_game();
      n_checks++;
      if ({winner, strike1, ball1, strike2, ball2, input_number, on_game, cur_player} !== 24'd0) begin
         n_fail++;
         $display("FAIL draw_restart: win=%0d s1=%0d b1=%0d s2=%0d b2=%0d num=%h on=%b cur=%b expected all 0",
                  winner, strike1, ball1, strike2, ball2, input_number, on_game, cur_player);
      end
      enter_guess(12'h987);
      n_checks++;
      if ({cur_player, on_game, button_pressed_p1} !== 3'b100) begin
         n_fail++;
         $display("FAIL draw_restart_set_p1: cur,on,p1=%b expected 100",
                  {cur_player, on_game, button_pressed_p1});
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      key_valid  = 1'b0;
      key_code   = 4'h0;
      game_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset_state();
      test_secrets();
      test_score();
      test_errors();
      test_reset_mid_play();
      test_win();
      test_draw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
